mix_grad_update: RTL and testbench

Parameter-update reader for the mix layers. For one selected mix layer, it sweeps the accumulated gradient memories that the backward-grad pass fills. It applies a shift-based SGD step to the matching weight/bias parameter memories and clears each gradient word as it is consumed, so the next mini-batch starts from zero. It runs in the optimizer phase after all backward passes, under the training controller's run/valid handshake.

---
 rtl/mix_grad_update.sv | 181 ++++++++++++++++++
 tb/tb_mix_grad_update.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_grad_update.sv
`default_nettype none
// ============================================================================
// Module  : mix_grad_update
// Brief   : Shift-based SGD step over one mix layer's weight/bias memories,
//           clearing each gradient entry as it is consumed.
// Revision: 1.0 - initial release
// ============================================================================
module mix_grad_update #(
  parameter int HID_DIM    = 24,
  parameter int DATA_N     = 8,
  parameter int N_LEN_W    = 16,
  parameter int LR_SHIFT   = 5,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [1:0]                  layer_sel,
  output logic                        valid,
  output logic [ADDR_WIDTH-1:0]       raddr_w,
  input  logic [DATA_N*N_LEN_W-1:0]   rdata_grad_w,
  input  logic [DATA_N*N_LEN_W-1:0]   rdata_param_w,
  output logic [ADDR_WIDTH-1:0]       raddr_b,
  input  logic [N_LEN_W-1:0]          rdata_grad_b,
  input  logic [N_LEN_W-1:0]          rdata_param_b,
  output logic                        we_w,
  output logic [ADDR_WIDTH-1:0]       waddr_w,
  output logic [DATA_N*N_LEN_W-1:0]   wdata_w,
  output logic                        we_b,
  output logic [ADDR_WIDTH-1:0]       waddr_b,
  output logic [N_LEN_W-1:0]          wdata_b
);

  localparam int                    c_w_words_i = HID_DIM * HID_DIM / DATA_N;
  localparam logic [ADDR_WIDTH-1:0] c_w_words   = ADDR_WIDTH'(c_w_words_i);
  localparam logic [ADDR_WIDTH-1:0] c_w_last    = ADDR_WIDTH'(c_w_words_i - 1);
  localparam logic [ADDR_WIDTH-1:0] c_hid       = ADDR_WIDTH'(HID_DIM);
  localparam int                    c_kb_w      = $clog2(HID_DIM + 1);
  localparam logic [c_kb_w-1:0]     c_kb_end    = c_kb_w'(HID_DIM);
  localparam logic [c_kb_w-1:0]     c_kb_last   = c_kb_w'(HID_DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_kw;
  logic [c_kb_w-1:0]       r_kb;
  logic                    r_drain;
  logic                    r_rd_vld_w;
  logic                    r_rd_vld_b;
  logic [ADDR_WIDTH-1:0]   r_rd_addr_w;
  logic [ADDR_WIDTH-1:0]   r_rd_addr_b;

  logic [ADDR_WIDTH-1:0]   w_base_w;
  logic [ADDR_WIDTH-1:0]   w_base_b;
  logic                    w_pipe_on;
  logic [DATA_N*N_LEN_W-1:0] w_new_w;
  logic [N_LEN_W-1:0]      w_new_b;

  // param - (grad >>> LR_SHIFT) with one guard bit; guard/sign disagreement means overflow
  function automatic logic [N_LEN_W-1:0] sgd_step(input logic [N_LEN_W-1:0] param,
                                                   input logic [N_LEN_W-1:0] grad);
    logic [N_LEN_W-1:0] delta;
    logic [N_LEN_W:0]   diff;
    delta = $signed(grad) >>> LR_SHIFT;
    diff  = {param[N_LEN_W-1], param} - {delta[N_LEN_W-1], delta};
    if (diff[N_LEN_W] != diff[N_LEN_W-1])
      sgd_step = diff[N_LEN_W] ? {1'b1, {(N_LEN_W-1){1'b0}}} : {1'b0, {(N_LEN_W-1){1'b1}}};
    else
      sgd_step = diff[N_LEN_W-1:0];
  endfunction

  for (genvar i = 0; i < DATA_N; i++) begin : g_lane
    assign w_new_w[i*N_LEN_W +: N_LEN_W] = sgd_step(rdata_param_w[i*N_LEN_W +: N_LEN_W],
                                                     rdata_grad_w[i*N_LEN_W +: N_LEN_W]);
  end

  assign w_new_b   = sgd_step(rdata_param_b, rdata_grad_b);
  assign w_base_w  = ADDR_WIDTH'(layer_sel) * c_w_words;
  assign w_base_b  = ADDR_WIDTH'(layer_sel) * c_hid;
  assign w_pipe_on = ((r_state == S_BUSY) || (r_state == S_DRAIN)) && run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_kw        <= '0;
      r_kb        <= '0;
      r_drain     <= 1'b0;
      r_rd_vld_w  <= 1'b0;
      r_rd_vld_b  <= 1'b0;
      r_rd_addr_w <= '0;
      r_rd_addr_b <= '0;
      valid       <= 1'b0;
      raddr_w     <= '0;
      raddr_b     <= '0;
      we_w        <= 1'b0;
      waddr_w     <= '0;
      wdata_w     <= '0;
      we_b        <= 1'b0;
      waddr_b     <= '0;
      wdata_b     <= '0;
    end else begin
      // Read data returns one cycle after the address; the write stage follows it.
      r_rd_vld_w  <= (r_state == S_BUSY) && run;
      r_rd_vld_b  <= (r_state == S_BUSY) && run && (r_kb != c_kb_end);
      r_rd_addr_w <= raddr_w;
      r_rd_addr_b <= raddr_b;
      we_w        <= w_pipe_on && r_rd_vld_w;
      we_b        <= w_pipe_on && r_rd_vld_b;
      if (w_pipe_on && r_rd_vld_w) begin
        waddr_w <= r_rd_addr_w;
        wdata_w <= w_new_w;
      end
      if (w_pipe_on && r_rd_vld_b) begin
        waddr_b <= r_rd_addr_b;
        wdata_b <= w_new_b;
      end

      case (r_state)
        S_IDLE: begin
          raddr_w <= w_base_w;
          raddr_b <= w_base_b;
          r_kw    <= '0;
          r_kb    <= '0;
          r_drain <= 1'b0;
          valid   <= 1'b0;
          if (run) begin
            if (layer_sel == 2'd3) begin
              r_state <= S_DONE;
              valid   <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!run) begin
            r_state <= S_IDLE;
            r_kw    <= '0;
            r_kb    <= '0;
          end else begin
            if (r_kw == c_w_last) begin
              r_state <= S_DRAIN;
            end else begin
              r_kw    <= r_kw + 1'b1;
              raddr_w <= raddr_w + 1'b1;
            end
            // Bias sweep is shorter; its address parks on the last entry.
            if (r_kb != c_kb_end)  r_kb    <= r_kb + 1'b1;
            if (r_kb < c_kb_last)  raddr_b <= raddr_b + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!run) begin
            r_state <= S_IDLE;
            r_kw    <= '0;
            r_kb    <= '0;
          end else if (r_drain) begin
            r_state <= S_DONE;
            valid   <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          if (!run) begin
            r_state <= S_IDLE;
            valid   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mix_grad_update.sv
`default_nettype none
// ============================================================================
// Module  : tb_mix_grad_update
// Brief   : Randomized self-checking bench for mix_grad_update with memory
//           models and a cycle-indexed behavioural reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mix_grad_update;

  localparam int HID_DIM    = 24;
  localparam int DATA_N     = 8;
  localparam int N_LEN_W    = 16;
  localparam int LR_SHIFT   = 5;
  localparam int ADDR_WIDTH = 9;
  localparam int W          = HID_DIM * HID_DIM / DATA_N;
  localparam int WW         = DATA_N * N_LEN_W;
  localparam int MEM        = 512;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  run = 1'b0;
  logic [1:0]            layer_sel = 2'd0;
  logic                  valid, we_w, we_b;
  logic [ADDR_WIDTH-1:0] raddr_w, raddr_b, waddr_w, waddr_b;
  logic [WW-1:0]         rdata_grad_w, rdata_param_w, wdata_w;
  logic [N_LEN_W-1:0]    rdata_grad_b, rdata_param_b, wdata_b;

  mix_grad_update #(
    .HID_DIM(HID_DIM), .DATA_N(DATA_N), .N_LEN_W(N_LEN_W),
    .LR_SHIFT(LR_SHIFT), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .layer_sel(layer_sel), .valid(valid),
    .raddr_w(raddr_w), .rdata_grad_w(rdata_grad_w), .rdata_param_w(rdata_param_w),
    .raddr_b(raddr_b), .rdata_grad_b(rdata_grad_b), .rdata_param_b(rdata_param_b),
    .we_w(we_w), .waddr_w(waddr_w), .wdata_w(wdata_w),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b)
  );

  always #5 clk = ~clk;

  logic [WW-1:0]      gw[MEM], pw[MEM], init_gw[MEM], init_pw[MEM], exp_pw[MEM];
  logic [N_LEN_W-1:0] gb[MEM], pb[MEM], init_gb[MEM], init_pb[MEM], exp_pb[MEM];
  int fill_mode = 0;

  // Memory models: 1-cycle read latency; a write updates param and clears grad
  always @(posedge clk) begin
    if (fill_mode != 0) begin
      for (int a = 0; a < MEM; a++) begin
        gw[a] <= {$urandom, $urandom, $urandom, $urandom};
        pw[a] <= {$urandom, $urandom, $urandom, $urandom};
        gb[a] <= 16'($urandom);
        pb[a] <= 16'($urandom);
      end
      if (fill_mode == 2) begin
        gw[72] <= {$urandom, $urandom, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0100};
        pw[72] <= {$urandom, $urandom, 16'h7FFF, 16'h8001, 16'h0010, 16'h0080};
        gb[24] <= 16'h0100;
        pb[24] <= 16'h0080;
      end
    end else begin
      rdata_grad_w  <= gw[raddr_w];
      rdata_param_w <= pw[raddr_w];
      rdata_grad_b  <= gb[raddr_b];
      rdata_param_b <= pb[raddr_b];
      if (we_w) begin
        pw[waddr_w] <= wdata_w;
        gw[waddr_w] <= '0;
      end
      if (we_b) begin
        pb[waddr_b] <= wdata_b;
        gb[waddr_b] <= '0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: floor(grad / 2^LR_SHIFT), subtract, clamp to the signed range
  function automatic logic [N_LEN_W-1:0] sgd(input logic [N_LEN_W-1:0] p, input logic [N_LEN_W-1:0] g);
    int pv, gv, q, d, n, lim;
    q   = 1 << LR_SHIFT;
    lim = 1 << (N_LEN_W - 1);
    pv  = int'($signed(p));
    gv  = int'($signed(g));
    d   = (gv >= 0) ? gv / q : -((-gv + q - 1) / q);
    n   = pv - d;
    if (n > lim - 1) n = lim - 1;
    else if (n < -lim) n = -lim;
    return n[N_LEN_W-1:0];
  endfunction

  function automatic logic [WW-1:0] sgd_word(input logic [WW-1:0] p, input logic [WW-1:0] g);
    logic [WW-1:0] r;
    for (int i = 0; i < DATA_N; i++)
      r[i*N_LEN_W +: N_LEN_W] = sgd(p[i*N_LEN_W +: N_LEN_W], g[i*N_LEN_W +: N_LEN_W]);
    return r;
  endfunction

  // Pass context, owned by the driver
  bit act = 1'b0;
  bit inv_mode = 1'b0;
  int abort_at = -1;
  int bw = 0;
  int bb = 0;

  int cyc = -1;
  always @(posedge clk) cyc <= act ? cyc + 1 : -1;

  int nwe_w, nwe_b, rise_cyc, first_w, last_w, first_b, last_b;
  bit m_live, m_ew, m_eb;

  always @(negedge clk) begin
    if (act && cyc >= 0) begin
      if (cyc == 0) begin
        nwe_w = 0; nwe_b = 0; rise_cyc = -1;
      end
      if (inv_mode) begin
        check("inv_valid", valid, 1'b1);
        check("inv_we_w", we_w, 1'b0);
        check("inv_we_b", we_b, 1'b0);
      end else begin
        m_live = (abort_at < 0) || (cyc <= abort_at);
        m_ew   = m_live && cyc >= 2 && cyc <= W + 1;
        m_eb   = m_live && cyc >= 2 && cyc <= HID_DIM + 1;
        check("we_w", we_w, m_ew);
        check("we_b", we_b, m_eb);
        check("valid", valid, (abort_at < 0) && cyc >= W + 2);
        if (m_live && cyc < W) begin
          check("raddr_w", raddr_w, bw + cyc);
          check("raddr_b", raddr_b, bb + ((cyc < HID_DIM) ? cyc : HID_DIM - 1));
        end
        if (m_ew && we_w) begin
          check("waddr_w", waddr_w, bw + cyc - 2);
          check("wdata_w", wdata_w, exp_pw[bw + cyc - 2]);
          if (nwe_w == 0) first_w = waddr_w;
          last_w = waddr_w;
        end
        if (m_eb && we_b) begin
          check("waddr_b", waddr_b, bb + cyc - 2);
          check("wdata_b", wdata_b, exp_pb[bb + cyc - 2]);
          if (nwe_b == 0) first_b = waddr_b;
          last_b = waddr_b;
        end
        if (we_w) nwe_w++;
        if (we_b) nwe_b++;
        if (valid && rise_cyc < 0) rise_cyc = cyc;
      end
    end
  end

  task automatic fill(input int mode);
    @(negedge clk); fill_mode = mode;
    @(negedge clk); fill_mode = 0;
  endtask

  task automatic snapshot();
    for (int a = 0; a < MEM; a++) begin
      init_gw[a] = gw[a]; init_pw[a] = pw[a];
      init_gb[a] = gb[a]; init_pb[a] = pb[a];
      exp_pw[a]  = sgd_word(pw[a], gw[a]);
      exp_pb[a]  = sgd(pb[a], gb[a]);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic do_pass(input int sel, input int ab, input int extra, input bit scramble);
    int nw, nb, bad, i;
    snapshot();
    bw = (sel == 3) ? 0 : sel * W;
    bb = sel * HID_DIM;
    @(negedge clk);
    layer_sel = 2'(sel); run = 1'b1; abort_at = ab; inv_mode = (sel == 3); act = 1'b1;
    if (sel == 3) begin
      repeat (4) @(negedge clk);
      run = 1'b0; act = 1'b0;
    end else if (ab >= 0) begin
      for (int c = 0; c <= ab; c++) begin
        @(negedge clk);
        if (scramble) layer_sel = 2'($urandom);
      end
      run = 1'b0;
      repeat (3) @(negedge clk);
      act = 1'b0;
    end else begin
      for (int c = 0; c <= W + 2 + extra; c++) begin
        @(negedge clk);
        if (scramble) layer_sel = 2'($urandom);
      end
      run = 1'b0; act = 1'b0;
    end
    @(negedge clk);
    check("valid_after_run_low", valid, 1'b0);
    check("we_after_run_low", {we_w, we_b}, 2'b00);
    nw = (sel == 3) ? 0 : ((ab < 0) ? W : clampi(ab - 1, W));
    nb = (sel == 3) ? 0 : ((ab < 0) ? HID_DIM : clampi(ab - 1, HID_DIM));
    bad = 0;
    for (int a = 0; a < MEM; a++) begin
      i = a - bw;
      if (i >= 0 && i < nw) begin
        if (pw[a] !== exp_pw[a] || gw[a] !== '0) bad++;
      end else if (pw[a] !== init_pw[a] || gw[a] !== init_gw[a]) bad++;
      i = a - bb;
      if (i >= 0 && i < nb) begin
        if (pb[a] !== exp_pb[a] || gb[a] !== '0) bad++;
      end else if (pb[a] !== init_pb[a] || gb[a] !== init_gb[a]) bad++;
    end
    check("mem_contents", bad, 0);
  endtask

  initial begin
    int sel, ab;
    #1 rst = 1'b1;
    #2;
    check("reset_ctl", {valid, we_w, we_b, waddr_w, waddr_b, raddr_w, raddr_b}, '0);
    check("reset_wdata", {wdata_w, wdata_b}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Layer 1 sweep with directed arithmetic corners at word 72 / bias 24
    fill(2);
    do_pass(1, -1, 3, 1'b1);
    check("l1_we_w_count", nwe_w, 72);
    check("l1_we_b_count", nwe_b, 24);
    check("l1_valid_rise", rise_cyc, 74);
    check("l1_waddr_w_first", first_w, 72);
    check("l1_waddr_w_last", last_w, 143);
    check("l1_waddr_b_first", first_b, 24);
    check("l1_waddr_b_last", last_b, 47);
    check("basic_update", pw[72][15:0], 16'h0078);
    check("negative_grad", pw[72][31:16], 16'h0011);
    check("sat_low", pw[72][47:32], 16'h8000);
    check("sat_high", pw[72][63:48], 16'h7FFF);
    check("grad_w_cleared", gw[72], '0);
    check("bias_update", pb[24], 16'h0078);
    check("grad_b_cleared", gb[24], 16'h0000);

    // Abort in cycle 30, then a clean rerun at layer 0
    fill(1);
    do_pass(2, 30, 0, 1'b1);
    fill(1);
    do_pass(0, -1, 0, 1'b0);
    check("rerun_first_waddr", first_w, 0);

    // Invalid select: done immediately, no writes
    fill(1);
    do_pass(3, -1, 0, 1'b0);

    // Asynchronous reset mid-pass
    fill(1);
    snapshot();
    bw = 2 * W; bb = 2 * HID_DIM;
    @(negedge clk);
    layer_sel = 2'd2; run = 1'b1; abort_at = -1; inv_mode = 1'b0; act = 1'b1;
    repeat (41) @(negedge clk);
    act = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ctl", {valid, we_w, we_b, waddr_w, waddr_b, raddr_w, raddr_b}, '0);
    check("rst_mid_wdata_w", wdata_w, '0);
    check("rst_mid_wdata_b", wdata_b, '0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized passes, some aborted
    for (int p = 0; p < 5; p++) begin
      fill(1);
      sel = $urandom_range(0, 2);
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, W + 1)) : -1;
      do_pass(sel, ab, $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
